// File: rtl/gray_counter_ctrl_if.sv
// Command handshake bundle for gray_counter_ctrl: valid/ready plus opcode and argument.
interface gray_counter_ctrl_if #(
    parameter int STEP_W = 4
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/gray_counter_ctrl.sv
// 3-bit binary/Gray step counter driven by LOAD/UP/DOWN/NOP commands.
// Define GRAY_CTRL_SAT_EN to make stepping saturate at 0/7 instead of wrapping.
module gray_counter_ctrl #(
    parameter int STEP_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    gray_counter_ctrl_if.slave  cmd,
    input  logic                abort,
    output logic [2:0]          count,
    output logic [2:0]          gray,
    output logic                busy,
    output logic                done,
    output logic                wrap
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0]        OP_LOAD  = 2'b00;
    localparam logic [1:0]        OP_UP    = 2'b01;
    localparam logic [1:0]        OP_DOWN  = 2'b10;
    localparam logic [STEP_W-1:0] REM_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] REM_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic [2:0]        count_r, count_nxt_s;
    logic [2:0]        gray_r;
    logic [STEP_W-1:0] rem_r, rem_nxt_s;
    logic              up_r, up_nxt_s;
    logic              wrap_r, wrap_nxt_s;
    logic              busy_r, done_r, ready_r;

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next-state, next-count and wrap-pulse decode
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        rem_nxt_s   = rem_r;
        up_nxt_s    = up_r;
        wrap_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd.cmd_valid && ready_r) begin
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            count_nxt_s = cmd.cmd_arg[2:0];
                            state_nxt_s = DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd.cmd_arg == REM_ZERO) begin
                                state_nxt_s = DONE;
                            end else begin
                                rem_nxt_s   = cmd.cmd_arg;
                                up_nxt_s    = (cmd.cmd_op == OP_UP);
                                state_nxt_s = RUN;
                            end
                        end
                        default: begin
                            state_nxt_s = DONE;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    rem_nxt_s   = REM_ZERO;
                    state_nxt_s = DONE;
                end else begin
`ifdef GRAY_CTRL_SAT_EN
                    // Saturating: the step is still consumed even when pinned at a rail
                    if (up_r) begin
                        count_nxt_s = (count_r == 3'd7) ? 3'd7 : count_r + 3'd1;
                    end else begin
                        count_nxt_s = (count_r == 3'd0) ? 3'd0 : count_r - 3'd1;
                    end
`else
                    if (up_r) begin
                        count_nxt_s = count_r + 3'd1;
                        wrap_nxt_s  = (count_r == 3'd7);
                    end else begin
                        count_nxt_s = count_r - 3'd1;
                        wrap_nxt_s  = (count_r == 3'd0);
                    end
`endif
                    rem_nxt_s = rem_r - REM_ONE;
                    if (rem_r == REM_ONE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                rem_nxt_s   = REM_ZERO;
            end
        endcase
    end

    // State and registered outputs; status flags decode the next state so they align with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= 3'd0;
            gray_r  <= 3'd0;
            rem_r   <= REM_ZERO;
            up_r    <= 1'b0;
            wrap_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            gray_r  <= bin2gray(count_nxt_s);
            rem_r   <= rem_nxt_s;
            up_r    <= up_nxt_s;
            wrap_r  <= wrap_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
            ready_r <= (state_nxt_s == IDLE);
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign count         = count_r;
    assign gray          = gray_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign wrap          = wrap_r;
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Self-checking bench for gray_counter_ctrl: directed scenarios plus random commands
// checked against a transaction-level arithmetic model of the counter.
module tb_gray_counter_ctrl;
    localparam int STEP_W = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       abort;
    logic [2:0] count, gray;
    logic       busy, done, wrap;
    int         checks = 0;
    int         errors = 0;
    int         model  = 0;

    gray_counter_ctrl_if #(.STEP_W(STEP_W)) cif ();

    gray_counter_ctrl #(.STEP_W(STEP_W)) dut (
        .clock (clock),
        .reset (reset),
        .cmd   (cif.slave),
        .abort (abort),
        .count (count),
        .gray  (gray),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int g_of(input int v);
        return (v ^ (v >> 1)) & 7;
    endfunction

    // Issue one command starting at a negedge with the DUT idle; checks every cycle until idle again.
    // hold keeps cmd_valid high with a follow-up command during the whole transaction.
    task automatic do_cmd(input int op, input int arg, input int abort_at,
                          input bit hold, input int hold_op, input int hold_arg);
        int n;
        int nxt;
        int wexp;
        check_eq("ready_before", cif.cmd_ready, 1);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op[1:0];
        cif.cmd_arg   = arg[STEP_W-1:0];
        @(negedge clock);
        if (hold) begin
            cif.cmd_op  = hold_op[1:0];
            cif.cmd_arg = hold_arg[STEP_W-1:0];
        end else begin
            cif.cmd_valid = 1'b0;
        end
        n = arg;
        if (op == 0) model = arg % 8;
        if (op == 0 || op == 3 || n == 0) begin
            check_eq("imm_count", count, model);
            check_eq("imm_gray", gray, g_of(model));
            check_eq("imm_done", done, 1);
            check_eq("imm_busy", busy, 0);
            check_eq("imm_wrap", wrap, 0);
            check_eq("imm_ready", cif.cmd_ready, 0);
        end else begin
            check_eq("e0_busy", busy, 1);
            check_eq("e0_count", count, model);
            check_eq("e0_ready", cif.cmd_ready, 0);
            for (int k = 1; k <= n; k++) begin
                abort = (k == abort_at);
                @(negedge clock);
                if (k == abort_at) begin
                    abort = 1'b0;
                    check_eq("abort_count", count, model);
                    check_eq("abort_done", done, 1);
                    check_eq("abort_busy", busy, 0);
                    check_eq("abort_wrap", wrap, 0);
                    break;
                end
                wexp = 0;
`ifdef GRAY_CTRL_SAT_EN
                if (op == 1) nxt = (model == 7) ? 7 : model + 1;
                else         nxt = (model == 0) ? 0 : model - 1;
`else
                if (op == 1) begin nxt = (model + 1) % 8; wexp = (model == 7); end
                else         begin nxt = (model + 7) % 8; wexp = (model == 0); end
`endif
                model = nxt;
                check_eq("step_count", count, model);
                check_eq("step_gray", gray, g_of(model));
                check_eq("step_wrap", wrap, wexp);
                check_eq("step_busy", busy, (k < n) ? 1 : 0);
                check_eq("step_done", done, (k == n) ? 1 : 0);
                check_eq("step_ready", cif.cmd_ready, 0);
            end
        end
        @(negedge clock);
        check_eq("after_done", done, 0);
        check_eq("after_ready", cif.cmd_ready, 1);
        check_eq("after_wrap", wrap, 0);
        check_eq("after_count", count, model);
    endtask

    initial begin
        int op, arg, ab;
        reset         = 1'b1;
        abort         = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b11;
        cif.cmd_arg   = '0;
        #2;
        check_eq("rst_ready", cif.cmd_ready, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_gray", gray, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wrap", wrap, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rel_ready", cif.cmd_ready, 1);

        do_cmd(1, 7, 0, 1'b0, 0, 0);            // UP 7 from 0
        do_cmd(0, 6, 0, 1'b0, 0, 0);            // LOAD 6
        do_cmd(1, 3, 0, 1'b0, 0, 0);            // UP 3 across 7->0
        do_cmd(0, 1, 0, 1'b0, 0, 0);            // LOAD 1
        do_cmd(2, 2, 0, 1'b0, 0, 0);            // DOWN 2 across 0->7
        do_cmd(1, 0, 0, 1'b0, 0, 0);            // UP 0
        do_cmd(3, 5, 0, 1'b0, 0, 0);            // NOP
        do_cmd(0, 0, 0, 1'b0, 0, 0);            // LOAD 0
        do_cmd(1, 10, 4, 1'b0, 0, 0);           // UP 10, abort on 4th RUN edge
        // Abort outside RUN has no effect
        abort = 1'b1;
        do_cmd(0, 13, 0, 1'b0, 0, 0);
        abort = 1'b0;
        // Second command held valid during RUN: accepted once, after IDLE
        do_cmd(1, 3, 0, 1'b1, 2, 2);
        do_cmd(2, 2, 0, 1'b0, 0, 0);
        repeat (3) begin
            @(negedge clock);
            check_eq("no_requeue_busy", busy, 0);
            check_eq("no_requeue_count", count, model);
        end

        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 3);
            arg = $urandom_range(0, 15);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, arg + 1) : 0;
            do_cmd(op, arg, ab, 1'b0, 0, 0);
        end

        // Reset mid-RUN at count 5
        do_cmd(0, 0, 0, 1'b0, 0, 0);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b01;
        cif.cmd_arg   = 4'd7;
        @(negedge clock);
        cif.cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("mid_count", count, 5);
        #2 reset = 1'b1;
        #1;
        model = 0;
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_gray", gray, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_ready", cif.cmd_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_ready", cif.cmd_ready, 1);
            check_eq("post_rst_count", count, 0);
        end
        do_cmd(1, 2, 0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_counter_ctrl.md
GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_W, default 4: width of the step-count field cmd_arg.
REQ-002 Port clock, input, 1: single rising-edge clock for all state.
REQ-003 Port reset, input, 1: reset, asynchronous and active-high.
REQ-004 Port cmd_valid, input, 1: command present.
REQ-005 Port cmd_ready, output, 1: controller can accept a command.
REQ-006 Port cmd_op, input, 2: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
REQ-007 Port cmd_arg, input, STEP_W: LOAD value is cmd_arg[2:0] (binary); UP/DOWN value is the step count N.
REQ-008 Port abort, input, 1: terminate a running UP/DOWN.
REQ-009 Port count, output, 3: registered binary count.
REQ-010 Port gray, output, 3: registered Gray code of count (count ^ (count>>1)).
REQ-011 Port busy, output, 1: high while stepping.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port wrap, output, 1: one-cycle pulse on a modulo-8 rollover.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-016 A command SHALL be accepted only on an edge where cmd_valid=1 and cmd_ready=1; cmd_valid in any other state SHALL be ignored and not queued.
REQ-017 On LOAD acceptance, count SHALL be set to cmd_arg[2:0] and gray to its Gray code at that same edge, and the FSM SHALL go to DONE.
REQ-018 On NOP acceptance, or on UP/DOWN acceptance with N=0, count SHALL be unchanged and the FSM SHALL go to DONE.
REQ-019 On UP/DOWN acceptance with N>0, remaining SHALL be set to N and the FSM SHALL go to RUN; no step SHALL occur at the acceptance edge.
REQ-020 On each edge in RUN with abort=0, count SHALL step +1 (UP) or -1 (DOWN) and remaining SHALL decrement; the edge where remaining goes 1->0 SHALL move the FSM to DONE.
REQ-021 UP/DOWN latency: the count changes at edges E1..EN after acceptance edge E0, done is high in the cycle after EN, and cmd_ready returns at EN+1.
REQ-022 Gray output: gray SHALL change by exactly one bit per step.
REQ-023 abort=1 on an edge in RUN SHALL suppress that step and move the FSM to DONE; abort SHALL be ignored outside RUN.
REQ-024 The DONE state SHALL last exactly one cycle and then return to IDLE.
REQ-025 Wrap (macro undefined): stepping 7->0 (UP) or 0->7 (DOWN) SHALL assert wrap for the cycle following that edge; wrap SHALL be 0 otherwise, including on LOAD.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, count=0, gray=000, remaining=0, busy=0, done=0, wrap=0.
REQ-027 cmd_ready SHALL be 0 while reset is high and 1 on the first cycle after release.
REQ-028 Reset during RUN SHALL discard the command with no done pulse.

Configuration
REQ-029 When macro GRAY_CTRL_SAT_EN is defined, count SHALL saturate: UP holds at 7 and DOWN holds at 0.
REQ-030 With GRAY_CTRL_SAT_EN defined, remaining steps SHALL still be consumed one per cycle, so latency is unchanged, and wrap SHALL be constant 0.
REQ-031 When GRAY_CTRL_SAT_EN is undefined, count SHALL wrap modulo 8 per REQ-025.

Verification
REQ-032 Reset, then UP N=7 -> count 1..7 on E1..E7, gray 001,011,010,110,111,101,100, done high one cycle after E7, wrap never high.
REQ-033 LOAD 6, then UP N=3 -> count 7,0,1; wrap high one cycle after the 7->0 edge; with GRAY_CTRL_SAT_EN: count 7,7,7, wrap 0, same done timing.
REQ-034 LOAD 1, then DOWN N=2 -> count 0,7, wrap pulse after 0->7; UP N=0 -> done the cycle after acceptance, count unchanged.
REQ-035 UP N=10 from 0, abort on the 4th RUN edge -> count stops at 3, done next cycle, cmd_ready the cycle after that.
REQ-036 cmd_valid held high during RUN with a second command -> not accepted until IDLE, then accepted exactly once.
REQ-037 Reset asserted mid-RUN at count 5 -> count=0, gray=000, busy=0 immediately, no done pulse, cmd_ready=1 after release.
